// File: rtl/sw_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sw_input_ctrl
//  Purpose  : Switch-bank word entry controller. The operator keys a word in
//             from the switches, either in one phase (sign/zero extended) or
//             in two phases (low half, then high half). The finished word is
//             held for the CPU until it is read (rd_ack) or cleared.
//  Ports    : clk            system clock, rising edge
//             rst_n          asynchronous active-low reset
//             confirm_pulse  confirm key, single-cycle pulse
//             clear_pulse    clear key, single-cycle pulse
//             sw[SW_W]       raw switch bank
//             wide_mode      0 = single-phase entry, 1 = two-phase entry
//             sign_ext       single-phase: 1 = sign-extend, 0 = zero-extend
//             rd_ack         CPU read acknowledge, consumes the word
//             data_out[2*SW_W] entered word (registered)
//             data_valid     word pending for the CPU
//             state_led[2]   IDLE=00, HALF=01, FULL=10
//             overrun        sticky: confirm pressed while a word was pending
//             entry_cnt[8]   number of words consumed by the CPU (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module sw_input_ctrl #(
    parameter int SW_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                confirm_pulse,
    input  logic                clear_pulse,
    input  logic [SW_W-1:0]     sw,
    input  logic                wide_mode,
    input  logic                sign_ext,
    input  logic                rd_ack,
    output logic [2*SW_W-1:0]   data_out,
    output logic                data_valid,
    output logic [1:0]          state_led,
    output logic                overrun,
    output logic [7:0]          entry_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HALF = 2'b01,
        ST_FULL = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam logic [2*SW_W-1:0] c_DATA_ZERO = '0;
    localparam logic [SW_W-1:0]   c_HALF_ZERO = '0;

    state_t              r_state;
    logic [2*SW_W-1:0]   r_data;
    logic                r_valid;
    logic                r_overrun;
    logic [7:0]          r_cnt;

    state_t              w_state_nx;
    logic [2*SW_W-1:0]   w_data_nx;
    logic                w_valid_nx;
    logic                w_overrun_nx;
    logic [7:0]          w_cnt_nx;
    logic [SW_W-1:0]     w_ext_hi;

    // Upper half for a single-phase entry: copies of the switch MSB when
    // sign extending, zeros otherwise.
    assign w_ext_hi = {SW_W{sw[SW_W-1] & sign_ext}};

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_data    <= c_DATA_ZERO;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            r_state   <= w_state_nx;
            r_data    <= w_data_nx;
            r_valid   <= w_valid_nx;
            r_overrun <= w_overrun_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / next-output logic. All decisions use the state held at
    // the start of the cycle; clear overrides every other event.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        w_data_nx    = r_data;
        w_valid_nx   = r_valid;
        w_overrun_nx = r_overrun;
        w_cnt_nx     = r_cnt;

        if (clear_pulse) begin
            // Discards any word; the consumed-word count is not a property
            // of the current word, so it is left alone.
            w_state_nx   = ST_IDLE;
            w_data_nx    = c_DATA_ZERO;
            w_valid_nx   = 1'b0;
            w_overrun_nx = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (confirm_pulse) begin
                        if (wide_mode) begin
                            w_state_nx = ST_HALF;
                            w_data_nx  = {c_HALF_ZERO, sw};
                        end else begin
                            w_state_nx = ST_FULL;
                            w_data_nx  = {w_ext_hi, sw};
                            w_valid_nx = 1'b1;
                        end
                    end
                end

                // Being in HALF is itself the latched wide-mode record, so the
                // live wide_mode/sign_ext inputs are not consulted here.
                ST_HALF: begin
                    if (confirm_pulse) begin
                        w_state_nx = ST_FULL;
                        w_data_nx  = {sw, r_data[SW_W-1:0]};
                        w_valid_nx = 1'b1;
                    end
                end

                // An ack wins over a simultaneous confirm; a lone confirm
                // only flags the overrun and leaves the pending word intact.
                ST_FULL: begin
                    if (rd_ack) begin
                        w_state_nx = ST_IDLE;
                        w_valid_nx = 1'b0;
                        w_cnt_nx   = r_cnt + 8'd1;
                    end else if (confirm_pulse) begin
                        w_overrun_nx = 1'b1;
                    end
                end

                // Unreachable encoding: fall back to IDLE with nothing pending.
                default: begin
                    w_state_nx = ST_IDLE;
                    w_valid_nx = 1'b0;
                end
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign state_led  = r_state;
    assign overrun    = r_overrun;
    assign entry_cnt  = r_cnt;

endmodule
`default_nettype wire
